// File: rtl/hypot_arb_seq.sv
// hypot_arb_seq: two-requester arbiter in front of a sequential hypotenuse unit.
// Computes floor(sqrt(x*x + y*y)) using shift-add squaring followed by a
// restoring square root. Both stages share one 17-bit accumulator.
module hypot_arb_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req0,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  output logic       gnt1,
  output logic [8:0] res,
  output logic       res_id,
  output logic       res_valid,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, MULX, MULY, SQRT, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [16:0] acc;
  logic [16:0] root;
  logic [7:0]  op_x, op_y;
  logic        job_id;
  logic        last_gnt;

  logic        grant0, grant1;
  logic [7:0]  mul_op;
  logic        mul_bit;
  logic [16:0] addend;
  logic [4:0]  shamt;
  logic [16:0] trial_bit;
  logic [17:0] trial;
  logic        fits;
  logic [16:0] root_n;

  // Arbitration and per-step datapath terms. On a tie, the requester that
  // was not granted last wins; last_gnt resets to 1 so req0 wins the first tie.
  always_comb begin
    grant0    = ena && (state == IDLE) && req0 && (!req1 || last_gnt);
    grant1    = ena && (state == IDLE) && req1 && (!req0 || !last_gnt);
    mul_op    = (state == MULX) ? op_x : op_y;
    mul_bit   = mul_op[cnt[2:0]];
    addend    = {9'd0, mul_op} << cnt[2:0];
    shamt     = 5'd16 - {cnt, 1'b0};
    trial_bit = 17'd1 << shamt;
    trial     = {1'b0, root} + {1'b0, trial_bit};
    fits      = {1'b0, acc} >= trial;
    root_n    = fits ? ((root >> 1) + trial_bit) : (root >> 1);
  end

  // Next-state and step-counter logic; nothing advances while ena is low.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (ena) begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state_n = MULX;
            cnt_n   = 4'd0;
          end
        end
        MULX: begin
          if (cnt == 4'd7) begin
            state_n = MULY;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        MULY: begin
          if (cnt == 4'd7) begin
            state_n = SQRT;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        SQRT: begin
          if (cnt == 4'd8) begin
            state_n = DONE;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Datapath: operand capture, squaring, square root and result load.
  // Grant pulses are cleared on every edge so they last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 17'd0;
      root     <= 17'd0;
      op_x     <= 8'd0;
      op_y     <= 8'd0;
      job_id   <= 1'b0;
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      res      <= 9'd0;
      res_id   <= 1'b0;
    end else begin
      gnt0 <= grant0;
      gnt1 <= grant1;
      if (ena) begin
        case (state)
          IDLE: begin
            if (grant0 || grant1) begin
              op_x     <= grant1 ? x1 : x0;
              op_y     <= grant1 ? y1 : y0;
              job_id   <= grant1;
              last_gnt <= grant1;
              acc      <= 17'd0;
              root     <= 17'd0;
            end
          end
          MULX, MULY: begin
            if (mul_bit) begin
              acc <= acc + addend;
            end
          end
          SQRT: begin
            if (fits) begin
              acc <= acc - trial[16:0];
            end
            root <= root_n;
            if (cnt == 4'd8) begin
              res    <= root_n[8:0];
              res_id <= job_id;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hypot_arb_seq.sv
// tb_hypot_arb_seq: directed vectors plus hand-written corner-case sequences.
module tb_hypot_arb_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       req0, req1;
  logic [7:0] x0, y0, x1, y1;
  logic       gnt0, gnt1;
  logic [8:0] res;
  logic       res_id;
  logic       res_valid;
  logic       busy;

  int checks;
  int failures;
  int gnt0_count;

  typedef struct {
    logic       id;
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  hypot_arb_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0(req0), .x0(x0), .y0(y0), .gnt0(gnt0),
    .req1(req1), .x1(x1), .y1(y1), .gnt1(gnt1),
    .res(res), .res_id(res_id), .res_valid(res_valid), .busy(busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every grant pulse to requester 0 seen mid-cycle.
  always @(negedge clk) begin
    if (gnt0 === 1'b1) gnt0_count++;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Waits for the grant pulse of requester `which`; found=1 when seen.
  // Returns #1 after the capture edge.
  task automatic wait_gnt(input logic which, output int found, output int wrong);
    found = 0;
    wrong = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(posedge clk); #1;
      if ((which ? gnt0 : gnt1) === 1'b1) wrong++;
      if ((which ? gnt1 : gnt0) === 1'b1) found = 1;
    end
  endtask

  // Counts edges until res_valid is seen; -1 if the bound expires.
  task automatic wait_done(input int max, output int k);
    int n;
    n = 0;
    k = -1;
    while (n < max && k < 0) begin
      @(posedge clk); #1;
      n++;
      if (res_valid === 1'b1) k = n;
    end
  endtask

  // Runs one complete job from a single requester and checks its result.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int found, wrong, k;
    if (v.id) begin x1 = v.x; y1 = v.y; req1 = 1'b1; end
    else      begin x0 = v.x; y0 = v.y; req0 = 1'b1; end
    wait_gnt(v.id, found, wrong);
    req0 = 1'b0;
    req1 = 1'b0;
    check_output({tag, " grant"}, found, 1);
    check_output({tag, " no_other_grant"}, wrong, 0);
    @(posedge clk); #1;
    check_output({tag, " grant_one_cycle"}, {31'd0, gnt0 | gnt1}, 0);
    wait_done(60, k);
    check_output({tag, " latency"}, (k < 0) ? -1 : k + 1, 25);
    check_output({tag, " res"}, {23'd0, res}, {23'd0, v.exp_res});
    check_output({tag, " res_id"}, {31'd0, res_id}, {31'd0, v.id});
    @(posedge clk); #1;
    check_output({tag, " valid_one_cycle"}, {31'd0, res_valid}, 0);
  endtask

  initial begin
    int found, wrong, k, cnt, g0_before;
    checks = 0;
    failures = 0;
    gnt0_count = 0;
    vecs[0] = '{1'b0, 8'd3,   8'd4,   9'd5};
    vecs[1] = '{1'b1, 8'd255, 8'd255, 9'd360};
    vecs[2] = '{1'b1, 8'd0,   8'd1,   9'd1};
    vecs[3] = '{1'b0, 8'd15,  8'd0,   9'd15};
    vecs[4] = '{1'b0, 8'd0,   8'd0,   9'd0};
    vecs[5] = '{1'b1, 8'd6,   8'd8,   9'd10};
    vecs[6] = '{1'b0, 8'd200, 8'd100, 9'd223};
    vecs[7] = '{1'b1, 8'd1,   8'd1,   9'd1};

    rst_n = 1'b0; ena = 1'b1; req0 = 1'b0; req1 = 1'b0;
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset busy", {31'd0, busy}, 0);
    check_output("reset res_valid", {31'd0, res_valid}, 0);
    check_output("reset res", {23'd0, res}, 0);
    check_output("reset grants", {30'd0, gnt1, gnt0}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesters held from reset: ties alternate, req0 first.
    rst_n = 1'b0;
    x0 = 8'd6; y0 = 8'd8; x1 = 8'd5; y1 = 8'd12;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_done(60, k);
      check_output($sformatf("tie%0d done", j), {31'd0, k > 0}, 1);
      check_output($sformatf("tie%0d res_id", j), {31'd0, res_id}, (j == 1) ? 1 : 0);
      check_output($sformatf("tie%0d res", j), {23'd0, res}, (j == 1) ? 13 : 10);
      if (j == 2) begin req0 = 1'b0; req1 = 1'b0; end
      @(posedge clk); #1;
    end

    // Reset pulse mid-job abandons the job.
    x0 = 8'd3; y0 = 8'd4; req0 = 1'b1;
    wait_gnt(1'b0, found, wrong);
    req0 = 1'b0;
    check_output("rstmid grant", found, 1);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rstmid busy", {31'd0, busy}, 0);
    check_output("rstmid res", {23'd0, res}, 0);
    check_output("rstmid res_valid", {31'd0, res_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1 || busy === 1'b1) cnt++;
    end
    check_output("rstmid abandoned", cnt, 0);
    apply_stimulus('{1'b1, 8'd0, 8'd1, 9'd1}, "after_rst");

    // Enable stall during SQRT and during DONE.
    x0 = 8'd6; y0 = 8'd8; req0 = 1'b1;
    wait_gnt(1'b0, found, wrong);
    req0 = 1'b0;
    check_output("stall grant", found, 1);
    repeat (18) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("stall res_held", {23'd0, res}, 1);
    check_output("stall no_valid", {31'd0, res_valid}, 0);
    ena = 1'b1;
    wait_done(40, k);
    check_output("stall latency", (k < 0) ? -1 : 23 + k, 30);
    check_output("stall res", {23'd0, res}, 10);
    ena = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check_output($sformatf("done_stall%0d valid", j), {31'd0, res_valid}, 1);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    check_output("done_stall release", {31'd0, res_valid}, 0);

    // A req0 blip while busy must be dropped.
    g0_before = gnt0_count;
    x1 = 8'd15; y1 = 8'd0; req1 = 1'b1;
    wait_gnt(1'b1, found, wrong);
    req1 = 1'b0;
    check_output("blip grant1", found, 1);
    repeat (5) @(posedge clk);
    #1;
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_done(40, k);
    check_output("blip res", {23'd0, res}, 15);
    check_output("blip res_id", {31'd0, res_id}, 1);
    cnt = 0;
    @(posedge clk); #1;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy === 1'b1) cnt++;
    end
    check_output("blip no_extra_job", cnt, 0);
    check_output("blip no_gnt0", gnt0_count - g0_before, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
